// File: rtl/rom_prefetch.sv
// rom_prefetch: instruction prefetch between a combinational boot ROM and the
// CPU decoder. Fetches one halfword per cycle into a small FIFO tagged with
// its halfword address, hands entries out over valid/ready, and restarts at a
// new address on a redirect (flush).
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   rom_addr, rom_rd   ROM halfword address (= fetch pointer), capture strobe
//   rom_data           ROM output, combinational from rom_addr
//   flush, flush_addr  redirect request and new fetch address
//   ins_valid/ready    decoder handshake for the head entry
//   ins_data/addr      head halfword and its address (0 when FIFO empty)
//
// Optional feature, macro ROM_PREFETCH_PERF_EN: adds fetch_count (pushes) and
// flush_count (flush cycles, saturating) outputs.
module rom_prefetch #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0,
   parameter int unsigned ROM_WORDS  = 512
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   output logic        rom_rd,
   input  logic [15:0] rom_data,
   input  logic        flush,
   input  logic [31:0] flush_addr,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [15:0] ins_data,
   output logic [31:0] ins_addr
`ifdef ROM_PREFETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] flush_count
`endif
);

   localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [31:0]      ROM_LIMIT = 32'(ROM_WORDS);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_END   = 1'b1
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] data;
   } entry_t;

   state_e           st_q, st_d;
   logic [31:0]      fetch_ptr_q, fetch_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];

   logic valid_c, pop_c, space_c, push_c;

   // Handshake terms. Flush blocks both push and pop in its cycle; the fetch
   // pointer range test only matters right after a reset to an address past
   // the ROM, where the first clock must move to END without fetching.
   always_comb begin
      valid_c = (count_q != '0) && !flush;
      pop_c   = valid_c && ins_ready;
      space_c = (count_q < DEPTH_C) || pop_c;
      push_c  = reset && (st_q == ST_FETCH) && (fetch_ptr_q < ROM_LIMIT)
                && space_c && !flush;
   end

   // Next-state: FIFO bookkeeping, fetch pointer and FETCH/END state.
   always_comb begin
      st_d        = st_q;
      fetch_ptr_d = fetch_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mem_d       = mem_q;

      if (flush) begin
         fetch_ptr_d = flush_addr;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         st_d        = (flush_addr < ROM_LIMIT) ? ST_FETCH : ST_END;
      end else begin
         if (push_c) begin
            mem_d[wr_ptr_q] = {fetch_ptr_q, rom_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            fetch_ptr_d     = fetch_ptr_q + 32'd1;
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if ((st_q == ST_FETCH) && (fetch_ptr_d >= ROM_LIMIT)) begin
            st_d = ST_END;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= ST_FETCH;
         fetch_ptr_q <= RESET_ADDR;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mem_q       <= '{default: '0};
      end else begin
         st_q        <= st_d;
         fetch_ptr_q <= fetch_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end

   // Head entry is forced to zero while the FIFO is empty.
   always_comb begin
      rom_addr  = fetch_ptr_q;
      rom_rd    = push_c;
      ins_valid = valid_c;
      ins_data  = (count_q != '0) ? mem_q[rd_ptr_q].data : 16'h0;
      ins_addr  = (count_q != '0) ? mem_q[rd_ptr_q].addr : 32'h0;
   end

`ifdef ROM_PREFETCH_PERF_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [15:0] flush_count_q, flush_count_d;

   // Performance counters; flush_count saturates.
   always_comb begin
      fetch_count_d = fetch_count_q;
      flush_count_d = flush_count_q;
      if (push_c) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
      if (flush && (flush_count_q != 16'hFFFF)) begin
         flush_count_d = flush_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_rom_prefetch.sv
// tb_rom_prefetch: directed bench for rom_prefetch with a pop scoreboard.
// Stimulus queues the {addr, data} entries it expects the decoder to pop; a
// monitor compares every accepted handshake against the queue head.
module tb_rom_prefetch;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rom_addr;
   logic        rom_rd;
   logic [15:0] rom_data;
   logic        flush;
   logic [31:0] flush_addr;
   logic        ins_valid;
   logic        ins_ready;
   logic [15:0] ins_data;
   logic [31:0] ins_addr;
`ifdef ROM_PREFETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [15:0] flush_count;
`endif

   int   checks    = 0;
   int   errors    = 0;
   int   pops      = 0;
   int   rd_pulses = 0;
   int   p0;
   ent_t exp_q [$];
   ent_t mon_e;

   always #5 clk = ~clk;

   rom_prefetch #(
      .DEPTH      (4),
      .RESET_ADDR (32'h0),
      .ROM_WORDS  (512)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rom_addr   (rom_addr),
      .rom_rd     (rom_rd),
      .rom_data   (rom_data),
      .flush      (flush),
      .flush_addr (flush_addr),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .ins_data   (ins_data),
      .ins_addr   (ins_addr)
`ifdef ROM_PREFETCH_PERF_EN
      ,
      .fetch_count (fetch_count),
      .flush_count (flush_count)
`endif
   );

   // ROM image: a few fixed words, a simple pattern elsewhere, DEAD past the end.
   function automatic logic [15:0] rom_fn(input logic [31:0] a);
      case (a)
         32'h000: rom_fn = 16'h0001;
         32'h001: rom_fn = 16'h0000;
         32'h002: rom_fn = 16'h0100;
         32'h080: rom_fn = 16'h0FB0;
         32'h081: rom_fn = 16'h0000;
         32'h082: rom_fn = 16'h3000;
         default: rom_fn = (a < 32'd512) ? (a[15:0] ^ 16'h5A00) : 16'hDEAD;
      endcase
   endfunction

   assign rom_data = rom_fn(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_pop(input logic [31:0] a, input logic [15:0] d);
      ent_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard compare on each accepted handshake; count rom_rd pulses.
   always @(negedge clk) begin
      if (reset && ins_valid && ins_ready) begin
         pops++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got addr %h data %h, expected no pop", ins_addr, ins_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ((ins_addr !== mon_e.addr) || (ins_data !== mon_e.data)) begin
               errors++;
               $display("FAIL pop_entry: got addr %h data %h, expected addr %h data %h",
                        ins_addr, ins_data, mon_e.addr, mon_e.data);
            end
         end
      end
      if (reset && rom_rd) rd_pulses++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values and the first stream
      reset = 1'b0; ins_ready = 1'b1; flush = 1'b0; flush_addr = 32'h0;
      #1;
      chk("rst_valid",    32'(ins_valid), 32'h0);
      chk("rst_data",     32'(ins_data),  32'h0);
      chk("rst_addr",     ins_addr,       32'h0);
      chk("rst_rom_rd",   32'(rom_rd),    32'h0);
      chk("rst_rom_addr", rom_addr,       32'h0);
      tick();
      reset = 1'b1;
      chk("valid_before_edge", 32'(ins_valid), 32'h0);
      expect_pop(32'h0, 16'h0001);
      expect_pop(32'h1, 16'h0000);
      expect_pop(32'h2, 16'h0100);
      tick();
      chk("first_valid", 32'(ins_valid), 32'h1);
      chk("first_addr",  ins_addr,       32'h0);
      tick(); tick(); tick();
      ins_ready = 1'b0;
      chk("stream_pops",  32'(pops),         32'd3);
      chk("stream_drain", 32'(exp_q.size()), 32'd0);

      // Reset mid-stream clears outputs without a clock
      reset = 1'b0;
      #1;
      chk("mid_rst_valid",    32'(ins_valid), 32'h0);
      chk("mid_rst_rom_rd",   32'(rom_rd),    32'h0);
      chk("mid_rst_rom_addr", rom_addr,       32'h0);
      chk("mid_rst_data",     32'(ins_data),  32'h0);
      chk("mid_rst_addr",     ins_addr,       32'h0);
      exp_q.delete();

      // Backpressure: FIFO fills to 4 then fetch stalls
      tick();
      reset = 1'b1;
      rd_pulses = 0;
      repeat (10) tick();
      chk("bp_rd_pulses", 32'(rd_pulses), 32'd4);
      chk("bp_rom_rd",    32'(rom_rd),    32'h0);
      chk("bp_rom_addr",  rom_addr,       32'h4);
      chk("bp_head_addr", ins_addr,       32'h0);
      expect_pop(32'h0, 16'h0001);
      expect_pop(32'h1, 16'h0000);
      expect_pop(32'h2, 16'h0100);
      expect_pop(32'h3, 16'h5A03);
      expect_pop(32'h4, 16'h5A04);
      expect_pop(32'h5, 16'h5A05);
      p0 = pops;
      ins_ready = 1'b1;
      repeat (6) tick();
      ins_ready = 1'b0;
      chk("bp_burst_pops", 32'(pops - p0),   32'd6);
      chk("bp_drain",      32'(exp_q.size()), 32'd0);

      // Flush with a full FIFO and ready high: no pop, empty next cycle
      ins_ready = 1'b1; flush = 1'b1; flush_addr = 32'h10; p0 = pops;
      #1;
      chk("fp_valid", 32'(ins_valid), 32'h0);
      tick();
      flush = 1'b0; ins_ready = 1'b0;
      chk("fp_pops",        32'(pops - p0),  32'd0);
      chk("fp_empty_valid", 32'(ins_valid),  32'h0);
      chk("fp_empty_addr",  ins_addr,        32'h0);
      chk("fp_rom_addr",    rom_addr,        32'h10);
      repeat (3) tick();
      chk("fill_valid", 32'(ins_valid), 32'h1);
      chk("fill_head",  ins_addr,       32'h10);

      // Flush to 0x80 with 3 entries queued
      flush = 1'b1; flush_addr = 32'h80; ins_ready = 1'b1;
      #1;
      chk("fl_valid_flush_cycle", 32'(ins_valid), 32'h0);
      expect_pop(32'h80, 16'h0FB0);
      expect_pop(32'h81, 16'h0000);
      expect_pop(32'h82, 16'h3000);
      tick();
      flush = 1'b0;
      chk("fl_valid_next", 32'(ins_valid), 32'h0);
      tick();
      chk("fl_valid_refill", 32'(ins_valid), 32'h1);
      chk("fl_head_addr",    ins_addr,       32'h80);
      chk("fl_head_data",    32'(ins_data),  32'h0FB0);
      repeat (3) tick();
      ins_ready = 1'b0;
      chk("fl_drain", 32'(exp_q.size()), 32'd0);

      // End of ROM: only 1FE and 1FF are fetched
      flush = 1'b1; flush_addr = 32'h1FE;
      tick();
      flush = 1'b0;
      rd_pulses = 0;
      repeat (8) tick();
      chk("end_rd_pulses", 32'(rd_pulses), 32'd2);
      chk("end_rom_rd",    32'(rom_rd),    32'h0);
      chk("end_rom_addr",  rom_addr,       32'h200);
      chk("end_valid",     32'(ins_valid), 32'h1);
      expect_pop(32'h1FE, 16'h5BFE);
      expect_pop(32'h1FF, 16'h5BFF);
      ins_ready = 1'b1;
      repeat (4) tick();
      chk("end_valid_drained", 32'(ins_valid),    32'h0);
      chk("end_rd_idle",       32'(rd_pulses),    32'd2);
      chk("end_drain",         32'(exp_q.size()), 32'd0);

      // Ten pushes from reset, then a held 3-cycle flush (last address wins)
      reset = 1'b0;
      #1;
      exp_q.delete();
      tick();
      reset = 1'b1; ins_ready = 1'b1;
      for (int a = 0; a < 9; a++) expect_pop(32'(a), rom_fn(32'(a)));
      repeat (10) tick();
      flush = 1'b1; flush_addr = 32'h20;
      #1;
      chk("hold_valid0", 32'(ins_valid), 32'h0);
      tick();
      flush_addr = 32'h30;
      chk("hold_valid1", 32'(ins_valid), 32'h0);
      tick();
      flush_addr = 32'h40;
      chk("hold_valid2", 32'(ins_valid), 32'h0);
      tick();
      flush = 1'b0; ins_ready = 1'b0;
      chk("hold_rom_addr", rom_addr,           32'h40);
      chk("hold_empty",    32'(ins_valid),     32'h0);
      chk("hold_drain",    32'(exp_q.size()),  32'd0);
`ifdef ROM_PREFETCH_PERF_EN
      chk("perf_fetch_count", fetch_count,       32'd10);
      chk("perf_flush_count", 32'(flush_count),  32'd3);
`endif
      tick();
      chk("hold_refill_valid", 32'(ins_valid), 32'h1);
      chk("hold_refill_head",  ins_addr,       32'h40);
      chk("hold_refill_data",  32'(ins_data),  32'h5A40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_prefetch.md
# rom_prefetch

Instruction prefetch stage between the boot ROM and the CPU decoder. It drives the ROM's halfword address and read strobe, and samples the ROM's combinational 16-bit output on each clock edge. It queues each halfword with its address in a small FIFO and hands halfwords to the decoder over a valid/ready handshake. A redirect (jump, call, interrupt) flushes the queue and restarts fetching at a new halfword address.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2–16.
- `RESET_ADDR`, 32'h0: halfword address fetched first after reset.
- `ROM_WORDS`, 512: number of valid ROM halfwords; fetching stops at this limit.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  32  halfword address to ROM; always equals `fetch_ptr`.
- `rom_rd`  out  1  high in every cycle in which `rom_data` is captured.
- `rom_data`  in  16  ROM output; combinational from `rom_addr`.
- `flush`  in  1  redirect request; single-cycle pulse or held.
- `flush_addr`  in  32  new fetch halfword address; valid while `flush` is high.
- `ins_valid`  out  1  head entry is available.
- `ins_ready`  in  1  decoder accepts the head entry.
- `ins_data`  out  16  head halfword.
- `ins_addr`  out  32  halfword address of the head entry.

## Operation
- State: `fetch_ptr` (32 b), FIFO storage of `DEPTH` × {addr 32, data 16}, `wr_ptr`/`rd_ptr` (log2 `DEPTH` bits, wrapping), `count` (0..`DEPTH`), FSM `st`.
- FSM states:
  - FETCH: fetching is allowed.
  - END: `fetch_ptr` ≥ `ROM_WORDS`; no further fetches.
- Reset (async, `reset`=0) sets:
  - `fetch_ptr`=`RESET_ADDR`, pointers=0, `count`=0, `st`=FETCH.
  - `rom_rd`=0, `ins_valid`=0, `ins_data`=0, `ins_addr`=0.
- `pop` = `ins_valid` & `ins_ready`.
- `space` = (`count` < `DEPTH`) | `pop`.
- `push` = `st`==FETCH & `space` & !`flush`. `rom_rd` = `push` (combinational).
- When `push` is high: store {`fetch_ptr`, `rom_data`} at `wr_ptr`, then `fetch_ptr` += 1.
- If the incremented `fetch_ptr` == `ROM_WORDS`, go to END. If `RESET_ADDR` ≥ `ROM_WORDS`, reset lands in FETCH and moves to END on the first clock without pushing.
- `ins_valid` = (`count` != 0) & !`flush`. `ins_data`/`ins_addr` show the entry at `rd_ptr`; they are 0 when `count`=0.
- `flush` overrides everything in its cycle:
  - No push and no pop.
  - Next cycle: `count`=0, `rd_ptr`=`wr_ptr`=0, `fetch_ptr`=`flush_addr`.
  - `st`=FETCH if `flush_addr` < `ROM_WORDS`, else END.
- END is left only by `flush` or `reset`.
- Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo `DEPTH`.
- `fetch_ptr` increments modulo 2^32. Wrap can only occur when `ROM_WORDS` = 2^32, which is not a supported configuration.
- Data width is fixed at 16 b. The block does not assemble 32-bit immediates; the decoder pops successive halfwords itself.

## Timing
- The ROM is combinational. Address and data lie in the same cycle, so each fetch costs one clock.
- Throughput: one halfword per cycle when the decoder keeps `ins_ready` high.
- Latency:
  - First `ins_valid` is high in the cycle after the first clock edge following reset release.
  - After a `flush` cycle, the first `ins_valid` (entry at `flush_addr`) is two cycles after `flush` was asserted: one refill push, then visible.
- Full FIFO with `ins_ready`=1: push and pop in the same cycle, with no bubble.
- Full FIFO with `ins_ready`=0: `rom_rd`=0 and `fetch_ptr` holds.
- `flush` held for N cycles keeps the FIFO empty and reloads `fetch_ptr` every cycle. The last `flush_addr` wins.
- Reset asserted mid-stream clears state immediately and asynchronously. Entries in flight are lost.

## Configuration
- `ROM_PREFETCH_PERF_EN` defined:
  - Adds outputs `fetch_count` (32 b, +1 per `push`) and `flush_count` (16 b, +1 per cycle with `flush`=1, saturating at 16'hFFFF).
  - Both counters reset to 0.
- `ROM_PREFETCH_PERF_EN` not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Reset stream:** release `reset`, hold `ins_ready`=1, ROM image with [0]=0001, [1]=0000, [2]=0100. Required: `ins_data` sequence 0001, 0000, 0100 with `ins_addr` 0, 1, 2 on consecutive cycles, first valid one cycle after release.
- **Backpressure:** `DEPTH`=4, `ins_ready`=0 for 10 cycles. Required: exactly 4 `rom_rd` pulses, then `rom_rd`=0 and `rom_addr`=4. Raise `ins_ready`: addresses 0–5 pop on 6 consecutive cycles with no bubble.
- **Flush:** flush to 32'h80 while the FIFO holds 3 entries. Required: `ins_valid`=0 in the flush cycle and the next. Then `ins_addr`=80, `ins_data`=0FB0, followed by 81/0000 and 82/3000.
- **End of ROM:** flush to 0x1FE with `ROM_WORDS`=512. Required: exactly two entries (1FE, 1FF), then `st`=END, `rom_rd`=0 indefinitely, `ins_valid`=0 after they drain.
- **Simultaneous flush and pop with a full FIFO:** required: no pop is counted and the FIFO is empty next cycle. Separately, assert `reset` mid-stream: all outputs return to their reset values in the same cycle.
- **Counters (`ROM_PREFETCH_PERF_EN`):** 10 pushes and a 3-cycle flush give `fetch_count`=10 and `flush_count`=3.
